prog_mealy_fsm: RTL and testbench
=================================

PROG_MEALY_FSM -- requirements
Module: prog_mealy_fsm

Interface
REQ-001 SHALL provide parameter N_IN, default 43: number of primary inputs x.
REQ-002 SHALL provide parameter N_OUT, default 18: number of Mealy outputs y.
REQ-003 SHALL provide parameter N_STATE, default 18: number of table entries/states; SW = max(1, clog2(N_STATE)), IW = max(1, clog2(N_IN)).
REQ-004 SHALL provide parameter RESET_STATE, default 0: state index loaded on reset.
REQ-005 SHALL provide port clk  input  1: single clock; all state updates on the falling edge.
REQ-006 SHALL provide port rst  input  1: asynchronous, active-high reset.
REQ-007 SHALL provide port x  input  N_IN: primary inputs.
REQ-008 SHALL provide port run  input  1: 1 = execute table; 0 = hold state, config permitted.
REQ-009 SHALL provide port cfg_we  input  1: table write strobe.
REQ-010 SHALL provide port cfg_addr  input  SW: entry index to write.
REQ-011 SHALL provide port cfg_data  input  1+IW+2*SW+2*N_OUT: {valid, sel, nxt1, nxt0, out1, out0}, MSB first.
REQ-012 SHALL provide port y  output  N_OUT: Mealy outputs.
REQ-013 SHALL provide port state_o  output  SW: current state index.
REQ-014 SHALL provide port err  output  1: sticky error flag.

Function
REQ-015 SHALL hold N_STATE table entries, each {valid, sel, nxt1, nxt0, out1, out0}.
REQ-016 SHALL define the test bit b = x[sel] of the current-state entry; b = 0 when sel >= N_IN.
REQ-017 SHALL drive y combinationally: run=1 and entry valid -> (b ? out1 : out0); otherwise all zero.
REQ-018 SHALL, on each falling clk edge with run=1 and entry valid, load state with (b ? nxt1 : nxt0).
REQ-019 SHALL hold state when run=0 or the current entry is invalid.
REQ-020 SHALL load RESET_STATE and set err when a selected next-state index is >= N_STATE.
REQ-021 SHALL write cfg_data into entry cfg_addr on a falling edge when cfg_we=1, run=0 and cfg_addr < N_STATE.
REQ-022 SHALL ignore the write and set err when cfg_we=1 with run=1 or cfg_addr >= N_STATE.
REQ-023 SHALL make a write to the current-state entry take effect on y immediately after that edge.
REQ-024 SHALL keep err at 1 until reset.
REQ-025 SHALL drive state_o from the state register (no extra latency).
REQ-026 SHALL NOT allow run to change state and table in the same edge; REQ-022 resolves this.

Reset
REQ-027 SHALL on rst=1, without waiting for a clock edge, set state = RESET_STATE, clear every valid bit and clear err; y is then all zero.
REQ-028 SHALL keep the design in reset while rst=1; writes and transitions are ignored.
REQ-029 SHALL resume normal operation at the first falling edge after rst deasserts; a mid-run reset needs reprogramming before execution.

Verification (defaults N_IN=43, N_OUT=18, N_STATE=18, SW=5, IW=6)
REQ-030 SHALL cover: rst pulse mid-cycle -> state_o=0, y=18'h0, err=0 immediately, with no clk edge needed.
REQ-031 SHALL cover: run=0; write entry 0 = {1, sel=9, nxt1=1, nxt0=5, out1=18'h00001, out0=18'h04000}; run=1, x[9]=1 -> y=18'h00001 at once, state_o=1 after the next falling edge; with x[9]=0 instead -> y=18'h04000, state_o=5.
REQ-032 SHALL cover: state 1 unprogrammed, run=1 for 4 falling edges -> y=0, state_o stays 1, err=0.
REQ-033 SHALL cover: cfg_we=1, run=1, cfg_addr=2 -> entry 2 unchanged (read back via execution), err=1 and stays 1.
REQ-034 SHALL cover: entry 0 with nxt1=20, x[sel]=1, run=1 -> state_o=0 after the edge, err=1; sel=50 -> out0/nxt0 path taken.
REQ-035 SHALL cover: rst asserted while running in state 5 -> state_o=0 and y=0 at once; after release with run=1 and no reprogramming -> state holds at 0.

Source files
------------

// File: rtl/prog_mealy_fsm.sv
// prog_mealy_fsm -- table-programmable Mealy state machine.
//
// Each of the N_STATE table entries is {valid, sel, nxt1, nxt0, out1, out0}.
// In the current state the entry picks one primary input bit b = x[sel]
// (b = 0 when sel is out of range). While running, y shows (b ? out1 : out0)
// combinationally, and the next falling edge loads (b ? nxt1 : nxt0).
// The table can only be written while run = 0.
//
// Ports:
//   clk       in   single clock; state and table update on the falling edge
//   rst       in   asynchronous active-high reset
//   x         in   [N_IN]  primary inputs
//   run       in   1 = execute the table, 0 = hold state (config allowed)
//   cfg_we    in   table write strobe
//   cfg_addr  in   [SW]    entry index to write
//   cfg_data  in   [CW]    {valid, sel, nxt1, nxt0, out1, out0}, MSB first
//   y         out  [N_OUT] Mealy outputs
//   state_o   out  [SW]    current state index
//   err       out  sticky error flag, cleared only by reset
module prog_mealy_fsm #(
   parameter int N_IN        = 43,
   parameter int N_OUT       = 18,
   parameter int N_STATE     = 18,
   parameter int RESET_STATE = 0,
   localparam int SW = (N_STATE > 1) ? $clog2(N_STATE) : 1,
   localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1,
   localparam int CW = 1 + IW + 2 * SW + 2 * N_OUT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_IN-1:0]   x,
   input  logic              run,
   input  logic              cfg_we,
   input  logic [SW-1:0]     cfg_addr,
   input  logic [CW-1:0]     cfg_data,
   output logic [N_OUT-1:0]  y,
   output logic [SW-1:0]     state_o,
   output logic              err
);

   // Entry payload without the valid bit.
   localparam int DW = CW - 1;

   // Limits widened by one bit so any index value can be range-checked.
   localparam logic [SW:0]   N_STATE_W = (SW + 1)'(N_STATE);
   localparam logic [IW:0]   N_IN_W    = (IW + 1)'(N_IN);
   localparam logic [SW-1:0] RESET_IDX = SW'(RESET_STATE);

   logic            valid_reg [N_STATE];
   logic [DW-1:0]   data_reg  [N_STATE];
   logic [SW-1:0]   state_reg, state_next;
   logic            err_reg, err_next;

   logic            cur_valid;
   logic [DW-1:0]   cur_data;
   logic [IW-1:0]   cur_sel;
   logic [SW-1:0]   cur_nxt1, cur_nxt0, nxt_sel;
   logic [N_OUT-1:0] cur_out1, cur_out0;
   logic            test_bit;
   logic            exec;
   logic            cfg_ok, cfg_bad;

   // Current-state entry lookup. The state register never holds an
   // out-of-range index, but the guard keeps the read well defined anyway.
   always_comb begin
      cur_valid = 1'b0;
      cur_data  = '0;
      if ({1'b0, state_reg} < N_STATE_W) begin
         cur_valid = valid_reg[state_reg];
         cur_data  = data_reg[state_reg];
      end
   end

   assign cur_sel  = cur_data[DW-1 -: IW];
   assign cur_nxt1 = cur_data[DW-1-IW -: SW];
   assign cur_nxt0 = cur_data[DW-1-IW-SW -: SW];
   assign cur_out1 = cur_data[2*N_OUT-1 -: N_OUT];
   assign cur_out0 = cur_data[N_OUT-1:0];

   // An out-of-range selector reads as 0, so the out0/nxt0 path is taken.
   always_comb begin
      test_bit = 1'b0;
      if ({1'b0, cur_sel} < N_IN_W)
         test_bit = x[cur_sel];
   end

   assign exec    = run && cur_valid;
   assign nxt_sel = test_bit ? cur_nxt1 : cur_nxt0;

   assign y       = exec ? (test_bit ? cur_out1 : cur_out0) : '0;
   assign state_o = state_reg;
   assign err     = err_reg;

   // Writing while running is refused, which also guarantees the table and
   // the state never change on the same edge.
   assign cfg_ok  = cfg_we && !run && ({1'b0, cfg_addr} < N_STATE_W);
   assign cfg_bad = cfg_we && (run || ({1'b0, cfg_addr} >= N_STATE_W));

   always_comb begin
      state_next = state_reg;
      err_next   = err_reg;
      if (exec) begin
         if ({1'b0, nxt_sel} < N_STATE_W) begin
            state_next = nxt_sel;
         end else begin
            state_next = RESET_IDX;
            err_next   = 1'b1;
         end
      end
      if (cfg_bad)
         err_next = 1'b1;
   end

   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= RESET_IDX;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         err_reg   <= err_next;
      end
   end

   // Per-entry storage. Only the valid bits are reset; payload contents are
   // irrelevant while the entry is invalid, so they carry no reset.
   for (genvar gi = 0; gi < N_STATE; gi++) begin : g_entry
      always_ff @(negedge clk or posedge rst) begin
         if (rst)
            valid_reg[gi] <= 1'b0;
         else if (cfg_ok && cfg_addr == SW'(gi))
            valid_reg[gi] <= cfg_data[CW-1];
      end

      always_ff @(negedge clk) begin
         if (!rst && cfg_ok && cfg_addr == SW'(gi))
            data_reg[gi] <= cfg_data[DW-1:0];
      end
   end

endmodule

// File: tb/tb_prog_mealy_fsm.sv
// tb_prog_mealy_fsm -- directed self-checking bench for prog_mealy_fsm at the
// default sizes (N_IN=43, N_OUT=18, N_STATE=18, SW=5, IW=6).
// Inputs change 1 time unit after the rising edge and outputs are sampled
// there as well, half a period away from the falling (active) edge.
module tb_prog_mealy_fsm;

   localparam int N_IN    = 43;
   localparam int N_OUT   = 18;
   localparam int N_STATE = 18;
   localparam int SW      = 5;
   localparam int IW      = 6;
   localparam int CW      = 1 + IW + 2 * SW + 2 * N_OUT;

   logic              clk;
   logic              rst;
   logic [N_IN-1:0]   x;
   logic              run;
   logic              cfg_we;
   logic [SW-1:0]     cfg_addr;
   logic [CW-1:0]     cfg_data;
   logic [N_OUT-1:0]  y;
   logic [SW-1:0]     state_o;
   logic              err;

   int total = 0;
   int bad   = 0;

   prog_mealy_fsm #(
      .N_IN(N_IN), .N_OUT(N_OUT), .N_STATE(N_STATE), .RESET_STATE(0)
   ) dut (
      .clk(clk), .rst(rst), .x(x), .run(run), .cfg_we(cfg_we),
      .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .y(y), .state_o(state_o), .err(err)
   );

   initial clk = 1'b1;
   always #5 clk = ~clk;

   function automatic logic [CW-1:0] ent(input logic v, input int sel,
                                         input int n1, input int n0,
                                         input logic [N_OUT-1:0] o1,
                                         input logic [N_OUT-1:0] o0);
      return {v, IW'(sel), SW'(n1), SW'(n0), o1, o0};
   endfunction

   // Write one entry with run=0; it commits on the falling edge in between.
   task automatic prog(input int addr, input logic [CW-1:0] data);
      @(posedge clk); #1;
      run      = 1'b0;
      cfg_we   = 1'b1;
      cfg_addr = SW'(addr);
      cfg_data = data;
      @(posedge clk); #1;
      cfg_we   = 1'b0;
      $display("prog entry %0d data=%h", addr, data);
   endtask

   // Reset pulse spanning one falling edge.
   task automatic do_reset();
      @(posedge clk); #2;
      run = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      #2 rst = 1'b1;   // before the first clock edge
      #1;
      total++; if (state_o !== 5'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state_o); end
      total++; if (y !== 18'h0) begin bad++; $display("FAIL reset_y got=%h want=0", y); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
      $display("reset: state=%0d y=%h err=%b", state_o, y, err);
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_take_one();
      do_reset();
      prog(0, ent(1'b1, 9, 1, 5, 18'h00001, 18'h04000));
      x = '0; x[9] = 1'b1; run = 1'b1;
      #1;
      total++; if (y !== 18'h00001) begin bad++; $display("FAIL take1_y got=%h want=00001", y); end
      total++; if (state_o !== 5'd0) begin bad++; $display("FAIL take1_state0 got=%0d want=0", state_o); end
      @(posedge clk); #1;
      total++; if (state_o !== 5'd1) begin bad++; $display("FAIL take1_state got=%0d want=1", state_o); end
      $display("take1: state=%0d", state_o);
      // State 1 was never programmed: outputs zero and state sticks.
      repeat (4) @(posedge clk);
      #1;
      total++; if (state_o !== 5'd1) begin bad++; $display("FAIL unprog_state got=%0d want=1", state_o); end
      total++; if (y !== 18'h0) begin bad++; $display("FAIL unprog_y got=%h want=0", y); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL unprog_err got=%b want=0", err); end
      $display("unprog: state=%0d y=%h err=%b", state_o, y, err);
      run = 1'b0;
   endtask

   task automatic test_take_zero();
      do_reset();
      prog(0, ent(1'b1, 9, 1, 5, 18'h00001, 18'h04000));
      x = '1; x[9] = 1'b0; run = 1'b1;
      #1;
      total++; if (y !== 18'h04000) begin bad++; $display("FAIL take0_y got=%h want=04000", y); end
      @(posedge clk); #1;
      total++; if (state_o !== 5'd5) begin bad++; $display("FAIL take0_state got=%0d want=5", state_o); end
      $display("take0: state=%0d", state_o);
      run = 1'b0;
   endtask

   task automatic test_cfg_while_run();
      do_reset();
      prog(0, ent(1'b1, 0, 2, 2, 18'h00111, 18'h00111));
      prog(2, ent(1'b1, 0, 2, 2, 18'h00222, 18'h00222));
      // Illegal write to entry 2 on the same edge that moves 0 -> 2.
      x = '0; run = 1'b1; cfg_we = 1'b1; cfg_addr = 5'd2;
      cfg_data = ent(1'b1, 0, 7, 7, 18'h3FFFF, 18'h3FFFF);
      #1;
      total++; if (y !== 18'h00111) begin bad++; $display("FAIL cfgrun_y0 got=%h want=00111", y); end
      @(posedge clk); #1;
      cfg_we = 1'b0;
      #1;
      total++; if (state_o !== 5'd2) begin bad++; $display("FAIL cfgrun_state got=%0d want=2", state_o); end
      total++; if (y !== 18'h00222) begin bad++; $display("FAIL cfgrun_y2 got=%h want=00222", y); end
      total++; if (err !== 1'b1) begin bad++; $display("FAIL cfgrun_err got=%b want=1", err); end
      repeat (2) @(posedge clk);
      #1;
      total++; if (state_o !== 5'd2) begin bad++; $display("FAIL cfgrun_hold got=%0d want=2", state_o); end
      total++; if (err !== 1'b1) begin bad++; $display("FAIL cfgrun_sticky got=%b want=1", err); end
      $display("cfgrun: state=%0d y=%h err=%b", state_o, y, err);
      run = 1'b0;
   endtask

   task automatic test_bad_next();
      do_reset();
      prog(0, ent(1'b1, 3, 20, 1, 18'h0AAAA, 18'h05555));
      x = '0; x[3] = 1'b1; run = 1'b1;
      #1;
      total++; if (y !== 18'h0AAAA) begin bad++; $display("FAIL badnxt_y got=%h want=0aaaa", y); end
      @(posedge clk); #1;
      total++; if (state_o !== 5'd0) begin bad++; $display("FAIL badnxt_state got=%0d want=0", state_o); end
      total++; if (err !== 1'b1) begin bad++; $display("FAIL badnxt_err got=%b want=1", err); end
      $display("badnxt: state=%0d err=%b", state_o, err);
      // Selector beyond N_IN reads as 0 even with every input high.
      do_reset();
      prog(0, ent(1'b1, 50, 7, 4, 18'h000F0, 18'h00F00));
      x = '1; run = 1'b1;
      #1;
      total++; if (y !== 18'h00F00) begin bad++; $display("FAIL badsel_y got=%h want=00f00", y); end
      @(posedge clk); #1;
      total++; if (state_o !== 5'd4) begin bad++; $display("FAIL badsel_state got=%0d want=4", state_o); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL badsel_err got=%b want=0", err); end
      $display("badsel: state=%0d err=%b", state_o, err);
      run = 1'b0;
   endtask

   task automatic test_mid_reset();
      do_reset();
      prog(0, ent(1'b1, 0, 5, 5, 18'h00001, 18'h00001));
      prog(5, ent(1'b1, 0, 5, 5, 18'h3C3C3, 18'h3C3C3));
      x = '0; run = 1'b1;
      @(posedge clk); #1;
      total++; if (state_o !== 5'd5) begin bad++; $display("FAIL midrst_pre got=%0d want=5", state_o); end
      total++; if (y !== 18'h3C3C3) begin bad++; $display("FAIL midrst_prey got=%h want=3c3c3", y); end
      #2 rst = 1'b1;
      #1;
      total++; if (state_o !== 5'd0) begin bad++; $display("FAIL midrst_state got=%0d want=0", state_o); end
      total++; if (y !== 18'h0) begin bad++; $display("FAIL midrst_y got=%h want=0", y); end
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total++; if (state_o !== 5'd0) begin bad++; $display("FAIL midrst_hold got=%0d want=0", state_o); end
      total++; if (y !== 18'h0) begin bad++; $display("FAIL midrst_holdy got=%h want=0", y); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL midrst_err got=%b want=0", err); end
      $display("midrst: state=%0d y=%h err=%b", state_o, y, err);
      run = 1'b0;
   endtask

   initial begin
      rst = 1'b0; run = 1'b0; cfg_we = 1'b0; x = '0;
      cfg_addr = '0; cfg_data = '0;
      test_reset();
      test_take_one();
      test_take_zero();
      test_cfg_while_run();
      test_bad_next();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
